sdrc_emulator: RTL and testbench

//  BRAM-backed responder for the Gowin SDRC user interface (IPUG943-style command port).

---
 rtl/sdrc_emulator.sv | 166 ++++++++++++++++
 tb/tb_sdrc_emulator.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/sdrc_emulator.sv
// sdrc_emulator: BRAM-backed stand-in for the Gowin SDRC user command port.
// Define SDRC_EMU_PROTOCOL_CHECK_EN to enable the sticky O_protocol_error checker.
module sdrc_emulator #(
    parameter int MemWordsBitWidth    = 12,
    parameter int AddressShift        = 0,
    parameter int InitCycles          = 16,
    parameter int ReadLatency         = 3,
    parameter int WriteRecoveryCycles = 4,
    parameter int RefreshCycles       = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        I_sdrc_cmd_en,
    input  logic [2:0]  I_sdrc_cmd,
    input  logic        I_sdrc_precharge_ctrl,
    input  logic        I_sdram_power_down,
    input  logic        I_sdram_selfrefresh,
    input  logic [20:0] I_sdrc_addr,
    input  logic [3:0]  I_sdrc_dqm,
    input  logic [31:0] I_sdrc_data,
    input  logic [7:0]  I_sdrc_data_len,
    output logic [31:0] O_sdrc_data,
    output logic        O_sdrc_init_done,
    output logic        O_sdrc_cmd_ack,
    output logic        O_protocol_error
);
    localparam int AW = MemWordsBitWidth;

    typedef enum logic [2:0] {
        INIT, IDLE, WRITE_BURST, WRITE_RECOVER, READ_WAIT, READ_BURST, REFRESH_WAIT
    } state_t;

    state_t          state;
    logic [31:0]     cnt;
    logic [7:0]      rem;
    logic [AW-1:0]   ptr;
    logic [31:0]     mem [2**AW];
    logic [20:0]     shifted;
    logic [AW-1:0]   base;
    logic [AW-1:0]   mem_addr;
    logic            accept;
    logic            wr_go;
    logic            rd_go;
    logic            mem_we;

    assign shifted  = I_sdrc_addr >> AddressShift;
    assign base     = shifted[AW-1:0];
    assign accept   = state == IDLE && I_sdrc_cmd_en;
    assign wr_go    = accept && I_sdrc_cmd == 3'b100;
    assign mem_we   = !rst && (wr_go || state == WRITE_BURST);
    assign rd_go    = !rst && ((state == READ_WAIT && cnt == 0) || (state == READ_BURST && rem != 0));
    assign mem_addr = wr_go ? base : ptr;

    // Beat 0 of a write is taken in the command cycle itself, so its address bypasses ptr.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (mem_we && !I_sdrc_dqm[b]) mem[mem_addr][8*b +: 8] <= I_sdrc_data[8*b +: 8];
        if (rst) O_sdrc_data <= '0;
        else if (rd_go) O_sdrc_data <= mem[mem_addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= INIT;
            cnt              <= '0;
            rem              <= '0;
            ptr              <= '0;
            O_sdrc_init_done <= 1'b0;
            O_sdrc_cmd_ack   <= 1'b0;
        end else begin
            O_sdrc_cmd_ack <= accept;
            case (state)
                INIT: begin
                    if (cnt == 32'(InitCycles - 1)) begin
                        state            <= IDLE;
                        O_sdrc_init_done <= 1'b1;
                    end else cnt <= cnt + 1;
                end
                IDLE: begin
                    if (I_sdrc_cmd_en) begin
                        rem <= I_sdrc_data_len;
                        case (I_sdrc_cmd)
                            3'b001: begin
                                state <= REFRESH_WAIT;
                                cnt   <= 32'(RefreshCycles - 1);
                            end
                            3'b100: begin
                                ptr   <= base + 1'b1;
                                state <= (I_sdrc_data_len == 0) ? WRITE_RECOVER : WRITE_BURST;
                                cnt   <= 32'(WriteRecoveryCycles - 1);
                            end
                            3'b101: begin
                                ptr   <= base;
                                state <= READ_WAIT;
                                cnt   <= 32'(ReadLatency - 2);
                            end
                            default: ;
                        endcase
                    end
                end
                WRITE_BURST: begin
                    ptr <= ptr + 1'b1;
                    rem <= rem - 1'b1;
                    if (rem == 8'd1) state <= WRITE_RECOVER;
                end
                WRITE_RECOVER, REFRESH_WAIT: begin
                    if (cnt == 0) state <= IDLE;
                    else cnt <= cnt - 1;
                end
                READ_WAIT: begin
                    if (cnt == 0) begin
                        ptr   <= ptr + 1'b1;
                        state <= READ_BURST;
                    end else cnt <= cnt - 1;
                end
                READ_BURST: begin
                    if (rem == 0) state <= IDLE;
                    else begin
                        ptr <= ptr + 1'b1;
                        rem <= rem - 1'b1;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

`ifdef SDRC_EMU_PROTOCOL_CHECK_EN
    logic [12:0] open_row;
    logic        row_valid;
    logic        viol;
    logic        unused_ok;

    assign unused_ok = ^{I_sdrc_precharge_ctrl, shifted};

    // Bank/row is taken as the address bits above an 8-bit column.
    always_comb begin
        viol = (I_sdrc_cmd_en && state != IDLE) || I_sdram_power_down || I_sdram_selfrefresh
            || (accept && (I_sdrc_cmd == 3'b000 || I_sdrc_cmd == 3'b110))
            || (accept && (I_sdrc_cmd == 3'b100 || I_sdrc_cmd == 3'b101)
                && (!row_valid || I_sdrc_addr[20:8] != open_row));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            O_protocol_error <= 1'b0;
            row_valid        <= 1'b0;
            open_row         <= '0;
        end else begin
            if (accept && I_sdrc_cmd == 3'b011) begin
                row_valid <= 1'b1;
                open_row  <= I_sdrc_addr[20:8];
            end
            if (viol) begin
                O_protocol_error <= 1'b1;
                $display("sdrc_emulator: protocol violation cmd=%b state=%0d", I_sdrc_cmd, state);
            end
        end
    end
`else
    logic unused_ok;

    assign unused_ok        = ^{I_sdrc_precharge_ctrl, I_sdram_power_down, I_sdram_selfrefresh, shifted};
    assign O_protocol_error = 1'b0;
`endif
endmodule

// File: tb/tb_sdrc_emulator.sv
// tb_sdrc_emulator: directed self-checking bench for sdrc_emulator.
module tb_sdrc_emulator;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_en = 1'b0;
    logic [2:0]  cmd = 3'b111;
    logic        pc = 1'b0;
    logic        pd = 1'b0;
    logic        sr = 1'b0;
    logic [20:0] addr = '0;
    logic [3:0]  dqm = '0;
    logic [31:0] wdata = '0;
    logic [7:0]  len = '0;
    logic [31:0] rdata;
    logic        init_done;
    logic        ack;
    logic        perr;
    int          passed = 0;
    int          failed = 0;
    int          total = 0;

`ifdef SDRC_EMU_PROTOCOL_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    always #5 clk = ~clk;

    sdrc_emulator dut (
        .clk                   (clk),
        .rst                   (rst),
        .I_sdrc_cmd_en         (cmd_en),
        .I_sdrc_cmd            (cmd),
        .I_sdrc_precharge_ctrl (pc),
        .I_sdram_power_down    (pd),
        .I_sdram_selfrefresh   (sr),
        .I_sdrc_addr           (addr),
        .I_sdrc_dqm            (dqm),
        .I_sdrc_data           (wdata),
        .I_sdrc_data_len       (len),
        .O_sdrc_data           (rdata),
        .O_sdrc_init_done      (init_done),
        .O_sdrc_cmd_ack        (ack),
        .O_protocol_error      (perr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Drives one command in cycle N and returns in cycle N+1 after checking its ack.
    task automatic do_cmd(input logic [2:0] c, input logic [20:0] a, input logic [7:0] l,
                          input logic [31:0] d, input logic [3:0] m, input string tag);
        cmd_en = 1'b1;
        cmd    = c;
        addr   = a;
        len    = l;
        wdata  = d;
        dqm    = m;
        tick();
        check({tag, " ack"}, 32'(ack), 32'd1);
        cmd_en = 1'b0;
        cmd    = 3'b111;
    endtask

    task automatic write_burst(input logic [20:0] a, input int l, input logic [31:0] d0,
                               input logic [31:0] step, input logic [3:0] m, input string tag);
        do_cmd(3'b100, a, 8'(l), d0, m, tag);
        for (int k = 1; k <= l; k++) begin
            wdata = d0 + 32'(k) * step;
            tick();
        end
        repeat (5) tick();
    endtask

    task automatic read_burst(input logic [20:0] a, input int l, input logic [31:0] d0,
                              input logic [31:0] step, input string tag);
        do_cmd(3'b101, a, 8'(l), 32'h0, 4'h0, tag);
        tick();
        tick();
        for (int k = 0; k <= l; k++) begin
            if (k > 0) tick();
            check($sformatf("%s beat%0d", tag, k), rdata, d0 + 32'(k) * step);
        end
        tick();
        check({tag, " hold"}, rdata, d0 + 32'(l) * step);
    endtask

    initial begin
        // 1: reset values, init_done timing, commands ignored during init
        repeat (3) tick();
        check("rst data", rdata, 32'h0);
        check("rst init_done", 32'(init_done), 32'd0);
        check("rst ack", 32'(ack), 32'd0);
        check("rst perr", 32'(perr), 32'd0);
        rst    = 1'b0;
        cmd_en = 1'b1;
        cmd    = 3'b011;
        for (int i = 1; i <= 16; i++) begin
            tick();
            check($sformatf("init ack%0d", i), 32'(ack), 32'd0);
            if (i == 15) check("init_done early", 32'(init_done), 32'd0);
            if (i == 16) check("init_done rise", 32'(init_done), 32'd1);
        end
        cmd_en = 1'b0;
        cmd    = 3'b111;
        tick();
        check("init ack late", 32'(ack), 32'd0);

        // 2: 8-beat write then 8-beat read
        do_cmd(3'b011, 21'h100, 8'd0, 32'h0, 4'h0, "act2");
        tick();
        write_burst(21'h100, 7, 32'h11, 32'h11, 4'h0, "wr2");
        read_burst(21'h100, 7, 32'h11, 32'h11, "rd2");

        // 3: byte masking
        do_cmd(3'b011, 21'h10, 8'd0, 32'h0, 4'h0, "act3");
        tick();
        write_burst(21'h10, 0, 32'hAABBCCDD, 32'h0, 4'b0000, "wr3a");
        write_burst(21'h10, 0, 32'h00112233, 32'h0, 4'b0101, "wr3b");
        read_burst(21'h10, 0, 32'h00BB22DD, 32'h0, "rd3");

        // 4: burst wrapping past the top of memory
        do_cmd(3'b011, 21'hFFE, 8'd0, 32'h0, 4'h0, "act4");
        tick();
        write_burst(21'hFFE, 3, 32'd1, 32'd1, 4'h0, "wr4");
        read_burst(21'hFFE, 3, 32'd1, 32'd1, "rd4");
        read_burst(21'h0, 0, 32'd3, 32'd0, "rd4w0");
        read_burst(21'h1, 0, 32'd4, 32'd0, "rd4w1");

        // 5: commands dropped while busy
        do_cmd(3'b011, 21'h20, 8'd0, 32'h0, 4'h0, "act5");
        tick();
        do_cmd(3'b100, 21'h20, 8'd0, 32'h12345678, 4'h0, "wr5");
        cmd_en = 1'b1;
        cmd    = 3'b100;
        addr   = 21'h20;
        wdata  = 32'hDEADBEEF;
        tick();
        check("drop wrec ack", 32'(ack), 32'd0);
        cmd_en = 1'b0;
        cmd    = 3'b111;
        repeat (5) tick();
        read_burst(21'h20, 0, 32'h12345678, 32'h0, "rd5a");
        do_cmd(3'b011, 21'h100, 8'd0, 32'h0, 4'h0, "act5b");
        tick();
        do_cmd(3'b101, 21'h100, 8'd3, 32'h0, 4'h0, "rd5b");
        tick();
        tick();
        check("rd5b beat0", rdata, 32'h11);
        cmd_en = 1'b1;
        cmd    = 3'b100;
        addr   = 21'h100;
        len    = 8'd0;
        wdata  = 32'h0;
        tick();
        check("drop rburst ack", 32'(ack), 32'd0);
        check("rd5b beat1", rdata, 32'h22);
        cmd_en = 1'b0;
        cmd    = 3'b111;
        tick();
        check("rd5b beat2", rdata, 32'h33);
        tick();
        check("rd5b beat3", rdata, 32'h44);
        tick();
        read_burst(21'h100, 0, 32'h11, 32'h0, "rd5c");
        check("perr", 32'(perr), 32'(CHK));

        // 6: reset in the middle of a read burst
        do_cmd(3'b101, 21'h100, 8'd7, 32'h0, 4'h0, "rd6");
        tick();
        tick();
        check("rd6 beat0", rdata, 32'h11);
        repeat (3) tick();
        check("rd6 beat3", rdata, 32'h44);
        rst = 1'b1;
        tick();
        check("rd6 rst data", rdata, 32'h0);
        check("rd6 rst init_done", 32'(init_done), 32'd0);
        check("rd6 rst ack", 32'(ack), 32'd0);
        tick();
        check("rd6 rst data hold", rdata, 32'h0);
        rst = 1'b0;
        repeat (16) tick();
        check("rd6 reinit", 32'(init_done), 32'd1);
        do_cmd(3'b011, 21'h100, 8'd0, 32'h0, 4'h0, "act6");
        tick();
        read_burst(21'h100, 1, 32'h11, 32'h11, "rd6b");
        read_burst(21'h10, 0, 32'h00BB22DD, 32'h0, "rd6c");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
